sprite_reg_writer: RTL and testbench
====================================

# sprite_reg_writer

Sprite register bank and command writer for the sprite graphics pipeline. It accepts sprite update commands over a valid/ready handshake and packs each one into the 32-bit sprite register format. It holds the command until vertical blanking, then commits it to the bank. All registers are exported flat to the per-sprite pixel hit comparators, which read the same format: active bit 29, X 28:19, Y 18:9.

## Interface
Parameters:
- NUM_SPRITES, 24: number of sprite registers in the bank.
- IDX_W, 5: width of the sprite index.
- SIZE_REG, 32: register width. The packing below is fixed for 32.

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block can accept a command this cycle.
- cmd_op  in  2  operation code:
  - 00 NOP
  - 01 WRITE
  - 10 MOVE
  - 11 DISABLE
- cmd_idx  in  IDX_W  target sprite index.
- cmd_x  in  10  X coordinate.
- cmd_y  in  10  Y coordinate.
- cmd_offset  in  9  sprite memory offset. Register bits 8:0.
- vblank  in  1  high during vertical blanking. Synchronous to clk.
- regs_out  out  NUM_SPRITES*32  all registers concatenated. Sprite i occupies bits [32*i+31:32*i].
- pending  out  1  a captured command is waiting to commit.
- err_idx  out  1  sticky flag. Set when an out-of-range index is committed.

## Operation
- Register format:
  - bits 31:30 are always 0.
  - bit 29 is the active bit.
  - bits 28:19 hold X.
  - bits 18:9 hold Y.
  - bits 8:0 hold the offset.
- State machine has two states, IDLE and HOLD.
  - IDLE: cmd_ready=1. When cmd_valid && cmd_ready, capture op, idx, x, y and offset into the hold register and go to HOLD.
  - HOLD: cmd_ready=0, pending=1. On the first cycle with vblank=1, commit the held command and return to IDLE.
- Commit effect on register[idx]:
  - WRITE: register becomes {2'b00, 1'b1, x, y, offset}.
  - MOVE: overwrite bits 28:9 with {x, y}. Bit 29 and bits 8:0 are unchanged.
  - DISABLE: clear bit 29. All other bits are unchanged.
  - NOP: no register changes. The FSM still passes through HOLD.
- idx >= NUM_SPRITES at commit: no register changes and err_idx is set to 1. err_idx clears only on reset.
- Commands presented in HOLD are not accepted. The producer must keep cmd_valid and its data stable until cmd_ready is seen.
- Only one command is ever in flight, and commits happen in acceptance order.
- No arithmetic is performed. Coordinates are stored verbatim as 10-bit fields. Any wrap or overflow of X + sprite size is the consumer's concern.

## Timing
- Reset (async assert) clears, immediately:
  - all regs_out to 0,
  - the hold register,
  - err_idx to 0,
  - state to IDLE, so pending=0 and cmd_ready=1.
- Reset asserted while in HOLD discards the held command. No partial commit is made.
- Acceptance at edge T puts the block in HOLD from T.
- Commit happens at the first edge T+k (k>=1) at which vblank=1 is sampled. regs_out shows the new value after that edge.
- cmd_ready rises after the commit edge, so minimum throughput is one command per 2 cycles.
- Worst-case latency is one full active frame, while waiting for vblank.
- vblank already high at acceptance gives commit at T+1.
- vblank dropping before the block samples it in HOLD means the command keeps waiting for the next blanking interval.
- cmd_ready is registered state, not combinational from cmd_valid.

## Configuration
- VBLANK_SYNC_EN defined: commits are gated on vblank as described above.
- VBLANK_SYNC_EN undefined:
  - vblank is ignored.
  - HOLD always commits at the next edge, giving a fixed one-cycle latency after acceptance.
  - The port stays present but unused.

## Test plan
- Reset check: assert reset mid-HOLD with a WRITE to idx 3 held. Required response:
  - all regs_out=0,
  - pending=0, cmd_ready=1,
  - register 3 stays 0 after reset is released.
- WRITE with vblank=1: idx=2, x=100, y=50, offset=7. Required response:
  - register 2 = 0x20000000 | (100<<19) | (50<<9) | 7, one edge after acceptance,
  - cmd_ready low for exactly one cycle.
- Gated commit: WRITE with vblank=0 for 20 cycles, then 1. Required response:
  - pending=1 and register unchanged for 20 cycles,
  - commit on the first vblank edge,
  - a second cmd_valid during the wait is not accepted.
- MOVE, then DISABLE, on a written sprite (x=10, y=20, offset=5). MOVE to x=639, y=479; then DISABLE. Required response:
  - after MOVE, offset stays 5 and bit 29 stays 1,
  - after DISABLE, only bit 29 clears.
- Out-of-range index: WRITE with idx=30 (NUM_SPRITES=24). Required response:
  - no regs_out change,
  - err_idx=1 and it stays set through later valid commands.
- Build without VBLANK_SYNC_EN, vblank held 0: back-to-back WRITEs to idx 0..3. Required response: each commits one edge after its acceptance, accepted every second cycle.

Source files
------------

// File: rtl/sprite_reg_writer.sv
// Sprite register bank with a one-deep command hold stage committed on vblank.
// Define VBLANK_SYNC_EN to gate commits on vblank; otherwise HOLD commits next edge.
module sprite_reg_writer #(
    parameter int NUM_SPRITES = 24,
    parameter int IDX_W       = 5,
    parameter int SIZE_REG    = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [IDX_W-1:0]                cmd_idx,
    input  logic [9:0]                      cmd_x,
    input  logic [9:0]                      cmd_y,
    input  logic [8:0]                      cmd_offset,
    input  logic                            vblank,
    output logic [NUM_SPRITES*SIZE_REG-1:0] regs_out,
    output logic                            pending,
    output logic                            err_idx
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_MOVE    = 2'b10;
    localparam logic [1:0] OP_DISABLE = 2'b11;

    typedef struct packed {
        logic [1:0]       op;
        logic [IDX_W-1:0] idx;
        logic [9:0]       x;
        logic [9:0]       y;
        logic [8:0]       offset;
    } hold_t;

    state_t                state;
    state_t                state_nxt;
    hold_t                 hold_q;
    logic                  accept;
    logic                  commit;
    logic                  commit_ok;
    logic                  idx_ok;
    logic [SIZE_REG-1:0]   bank [NUM_SPRITES];

`ifdef VBLANK_SYNC_EN
    assign commit_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign commit_ok     = 1'b1;
`endif

    assign accept = cmd_valid && cmd_ready;
    assign idx_ok = ({1'b0, hold_q.idx} < (IDX_W+1)'(NUM_SPRITES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        pending   = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = HOLD;
            end
            HOLD: begin
                pending = 1'b1;
                if (commit_ok) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else if (accept) begin
            hold_q <= '{op: cmd_op, idx: cmd_idx, x: cmd_x,
                        y: cmd_y, offset: cmd_offset};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) bank[i] <= '0;
        end else if (commit && idx_ok) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (hold_q.idx == IDX_W'(i)) begin
                    case (hold_q.op)
                        OP_WRITE:
                            bank[i] <= SIZE_REG'({2'b00, 1'b1, hold_q.x,
                                                  hold_q.y, hold_q.offset});
                        OP_MOVE:    bank[i][28:9] <= {hold_q.x, hold_q.y};
                        OP_DISABLE: bank[i][29]   <= 1'b0;
                        OP_NOP:     ;
                        default:    ;
                    endcase
                end
            end
        end
    end

    // Out-of-range commits are dropped but remembered until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 err_idx <= 1'b0;
        else if (commit && !idx_ok) err_idx <= 1'b1;
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_out
        assign regs_out[g*SIZE_REG +: SIZE_REG] = bank[g];
    end

endmodule

// File: tb/tb_sprite_reg_writer.sv
// Directed table-driven bench for sprite_reg_writer.
// Covers both the default build and the VBLANK_SYNC_EN build.
module tb_sprite_reg_writer;

    localparam int NS = 24;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [4:0]    cmd_idx;
    logic [9:0]    cmd_x;
    logic [9:0]    cmd_y;
    logic [8:0]    cmd_offset;
    logic          vblank;
    logic [NS*32-1:0] regs_out;
    logic          pending;
    logic          err_idx;

    int checks = 0;
    int errors = 0;
    logic [NS*32-1:0] exp_flat;

    sprite_reg_writer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_idx    (cmd_idx),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_offset (cmd_offset),
        .vblank     (vblank),
        .regs_out   (regs_out),
        .pending    (pending),
        .err_idx    (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  idx;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [8:0]  off;
        logic        upd;
        int          widx;
        logic [31:0] val;
        logic        err;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bank(input string nm);
        checks++;
        if (regs_out !== exp_flat) begin
            errors++;
            for (int i = 0; i < NS; i++) begin
                if (regs_out[32*i +: 32] !== exp_flat[32*i +: 32]) begin
                    $display("FAIL %s: reg%0d got %h expected %h", nm, i,
                             regs_out[32*i +: 32], exp_flat[32*i +: 32]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [31:0] pack(input logic [9:0] x,
                                         input logic [9:0] y,
                                         input logic [8:0] off);
        return {2'b00, 1'b1, x, y, off};
    endfunction

    // Starts #1 after an edge with the block idle; returns #1 after acceptance.
    task automatic send(input logic [1:0] op, input logic [4:0] idx,
                        input logic [9:0] x, input logic [9:0] y,
                        input logic [8:0] off);
        chk("ready_before_accept", {31'b0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_idx    = idx;
        cmd_x      = x;
        cmd_y      = y;
        cmd_offset = off;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_idx = '0;
        cmd_x = '0; cmd_y = '0; cmd_offset = '0; vblank = 1'b0;
        exp_flat = '0;

        tbl[0] = '{2'b01, 5'd2,  10'd100,  10'd50,  9'd7,   1'b1, 2,  32'h23206407, 1'b0};
        tbl[1] = '{2'b01, 5'd5,  10'd10,   10'd20,  9'd5,   1'b1, 5,  32'h20502805, 1'b0};
        tbl[2] = '{2'b10, 5'd5,  10'd639,  10'd479, 9'd0,   1'b1, 5,  32'h33FBBE05, 1'b0};
        tbl[3] = '{2'b11, 5'd5,  10'd1,    10'd1,   9'd1,   1'b1, 5,  32'h13FBBE05, 1'b0};
        tbl[4] = '{2'b00, 5'd2,  10'd0,    10'd0,   9'd0,   1'b0, 0,  32'h0,        1'b0};
        tbl[5] = '{2'b01, 5'd23, 10'd1023, 10'd1023, 9'd511, 1'b1, 23, 32'h3FFFFFFF, 1'b0};
        tbl[6] = '{2'b01, 5'd30, 10'd1,    10'd1,   9'd1,   1'b0, 0,  32'h0,        1'b1};
        tbl[7] = '{2'b01, 5'd24, 10'd2,    10'd2,   9'd2,   1'b0, 0,  32'h0,        1'b1};
        tbl[8] = '{2'b01, 5'd0,  10'd3,    10'd4,   9'd6,   1'b1, 0,  32'h20180806, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk_bank("reset_regs");
        chk("reset_pending", {31'b0, pending}, 32'd0);
        chk("reset_ready", {31'b0, cmd_ready}, 32'd1);
        chk("reset_err", {31'b0, err_idx}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // vblank high at acceptance: commit one edge later in either build
        vblank = 1'b1;
        for (int r = 0; r < 9; r++) begin
            send(tbl[r].op, tbl[r].idx, tbl[r].x, tbl[r].y, tbl[r].off);
            chk("hold_ready_low", {31'b0, cmd_ready}, 32'd0);
            chk("hold_pending", {31'b0, pending}, 32'd1);
            chk_bank("hold_regs_unchanged");
            @(posedge clk);
            #1;
            if (tbl[r].upd) exp_flat[32*tbl[r].widx +: 32] = tbl[r].val;
            chk_bank($sformatf("row%0d_regs", r));
            chk($sformatf("row%0d_err", r), {31'b0, err_idx}, {31'b0, tbl[r].err});
            chk("commit_ready", {31'b0, cmd_ready}, 32'd1);
            chk("commit_pending", {31'b0, pending}, 32'd0);
        end
        vblank = 1'b0;

`ifdef VBLANK_SYNC_EN
        send(2'b01, 5'd7, 10'd200, 10'd100, 9'd9);
        for (int k = 0; k < 20; k++) begin
            chk("gated_pending", {31'b0, pending}, 32'd1);
            chk("gated_ready", {31'b0, cmd_ready}, 32'd0);
            chk_bank("gated_regs_unchanged");
            if (k == 5) begin
                cmd_valid = 1'b1; cmd_op = 2'b01; cmd_idx = 5'd8;
                cmd_x = 10'd1; cmd_y = 10'd1; cmd_offset = 9'd1;
            end
            @(posedge clk);
            #1;
        end
        vblank = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        vblank = 1'b0;
        exp_flat[32*7 +: 32] = 32'h2640C809;
        chk_bank("gated_commit");
        chk("gated_commit_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("second_not_accepted", {31'b0, pending}, 32'd0);
        chk_bank("second_no_write");
`else
        // continuous valid: one acceptance every second cycle
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        for (int i = 0; i < 4; i++) begin
            cmd_idx = 5'(i);
            cmd_x = 10'(i + 1); cmd_y = 10'(2 * i); cmd_offset = 9'(i);
            chk("b2b_ready", {31'b0, cmd_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk("b2b_hold_ready", {31'b0, cmd_ready}, 32'd0);
            chk_bank("b2b_hold_regs");
            @(posedge clk);
            #1;
            exp_flat[32*i +: 32] = pack(10'(i + 1), 10'(2 * i), 9'(i));
            chk_bank($sformatf("b2b_commit%0d", i));
        end
        cmd_valid = 1'b0;
`endif

        // reset while a WRITE to sprite 3 is held
        send(2'b01, 5'd3, 10'd11, 10'd12, 9'd13);
        chk("pre_reset_pending", {31'b0, pending}, 32'd1);
        reset = 1'b1;
        #1;
        exp_flat = '0;
        chk_bank("mid_hold_reset_regs");
        chk("mid_hold_reset_pending", {31'b0, pending}, 32'd0);
        chk("mid_hold_reset_ready", {31'b0, cmd_ready}, 32'd1);
        chk("mid_hold_reset_err", {31'b0, err_idx}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        vblank = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_reg3", regs_out[32*3 +: 32], 32'h0);
        chk_bank("post_reset_regs");
        chk("post_reset_pending", {31'b0, pending}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
